mem_access_unit: RTL and testbench

- Load/store front end sitting directly upstream of the 8-bit data memory (datamem); the execute stage issues loads and stores into it.
- Stores are held in a small merging store buffer and written to memory only on idle cycles, so loads get the memory slot whenever they need it.
- Loads read memory combinationally, or forward from the store buffer, and return a registered response one cycle later.

---
 rtl/mem_access_unit.sv | 125 ++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store front end with a merging store buffer ahead of datamem.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int SB_DEPTH = 4,
  parameter int AW       = 8,
  parameter int DW       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [AW-1:0]               req_addr,
  input  logic [DW-1:0]               req_wdata,
  output logic                        resp_valid,
  output logic [DW-1:0]               resp_data,
  output logic                        mem_en,
  output logic [AW-1:0]               mem_write_addr,
  output logic [DW-1:0]               mem_write_data,
  output logic [AW-1:0]               mem_read_addr,
  input  logic [DW-1:0]               mem_read_data,
  output logic                        sb_empty,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth   = CW'(SB_DEPTH);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [PW-1:0] c_ptr_one = PW'(1);

  logic [AW-1:0]       r_addr [SB_DEPTH];
  logic [DW-1:0]       r_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_valid;
  logic [PW-1:0]       r_head;
  logic [PW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic                r_resp_valid;
  logic [DW-1:0]       r_resp_data;

  logic                w_hit;
  logic [PW-1:0]       w_hit_idx;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_drain;
  logic                w_enq;
  logic [DW-1:0]       w_load_data;

  // At most one valid entry can hold a given address, so the last hit wins trivially.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == req_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = PW'(i);
      end
    end
  end

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign req_ready   = !req_we || !w_full || w_hit;
  assign w_accept    = req_valid && req_ready;
  assign w_enq       = w_accept && req_we && !w_hit;
  // Requests own the cycle; the buffer only drains when nothing was accepted.
  assign w_drain     = !w_accept && !w_empty;
  assign w_load_data = w_hit ? r_data[w_hit_idx] : mem_read_data;

  assign mem_en         = w_drain;
  assign mem_write_addr = w_empty ? '0 : r_addr[r_head];
  assign mem_write_data = w_empty ? '0 : r_data[r_head];
  assign mem_read_addr  = req_addr;

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign sb_count   = r_count;
  assign sb_empty   = w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_valid      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      if (w_accept && req_we) begin
        if (w_hit) begin
          r_data[w_hit_idx] <= req_wdata;
        end else begin
          r_addr[r_tail]  <= req_addr;
          r_data[r_tail]  <= req_wdata;
          r_valid[r_tail] <= 1'b1;
          r_tail          <= r_tail + c_ptr_one;
        end
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_ptr_one;
      end
      if (w_enq) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_drain) begin
        r_count <= r_count - c_cnt_one;
      end
      r_resp_valid <= w_accept && !req_we;
      if (w_accept && !req_we) begin
        r_resp_data <= w_load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit with a datamem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       mem_en;
  logic [7:0] mem_write_addr;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_addr;
  logic [7:0] mem_read_data;
  logic       sb_empty;
  logic [2:0] sb_count;

  logic [7:0] mem [256];
  logic [7:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  int         wr_total = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.SB_DEPTH(4), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_en(mem_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  assign mem_read_data = mem[mem_read_addr];

  always @(posedge clk) begin
    if (mem_en) begin
      mem[mem_write_addr] <= mem_write_data;
      wlog_a.push_back(mem_write_addr);
      wlog_d.push_back(mem_write_data);
      wr_total <= wr_total + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_data !== 8'h00) begin errors++; $display("FAIL reset_resp_data got %h exp 00", resp_data); end
    checks++; if (sb_empty !== 1'b1 || sb_count !== 3'd0) begin errors++; $display("FAIL reset_occupancy got empty=%b count=%0d exp 1/0", sb_empty, sb_count); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_load;
    drive(1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    checks++; if (req_ready !== 1'b1 || mem_read_addr !== 8'h10) begin errors++; $display("FAIL load_issue got ready=%b raddr=%h exp 1/10", req_ready, mem_read_addr); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL load_mem_en got %b exp 0", mem_en); end
    tick;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'h5A) begin errors++; $display("FAIL load_resp got v=%b d=%h exp 1/5a", resp_valid, resp_data); end
    tick;
    checks++; if (resp_valid !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL load_pulse got v=%b en=%b exp 0/0", resp_valid, mem_en); end
  endtask

  task automatic test_forward;
    drive(1'b1, 1'b1, 8'h20, 8'h33);
    tick;
    drive(1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL fwd_no_drain got %b exp 0", mem_en); end
    tick;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'h33) begin errors++; $display("FAIL fwd_resp got v=%b d=%h exp 1/33", resp_valid, resp_data); end
    checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL fwd_count got %0d exp 1", sb_count); end
    #1;
    checks++; if (mem_en !== 1'b1 || mem_write_addr !== 8'h20 || mem_write_data !== 8'h33) begin errors++; $display("FAIL fwd_drain got en=%b a=%h d=%h exp 1/20/33", mem_en, mem_write_addr, mem_write_data); end
    tick;
    checks++; if (sb_count !== 3'd0 || mem[8'h20] !== 8'h33) begin errors++; $display("FAIL fwd_after got count=%0d mem=%h exp 0/33", sb_count, mem[8'h20]); end
  endtask

  task automatic test_merge;
    int base;
    base = wr_total;
    drive(1'b1, 1'b1, 8'h40, 8'h01);
    tick;
    drive(1'b1, 1'b1, 8'h40, 8'h02);
    tick;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL merge_count got %0d exp 1", sb_count); end
    for (int i = 0; i < 3; i++) tick;
    checks++; if (wr_total - base !== 1) begin errors++; $display("FAIL merge_drains got %0d exp 1", wr_total - base); end
    checks++; if (mem[8'h40] !== 8'h02) begin errors++; $display("FAIL merge_data got %h exp 02", mem[8'h40]); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] ea;
    logic [7:0] ed;
    base = wlog_a.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 8'h50 + 8'(i), 8'(i + 1));
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", i, req_ready); end
      tick;
    end
    drive(1'b1, 1'b1, 8'h54, 8'h05);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", req_ready); end
    checks++; if (mem_en !== 1'b1 || mem_write_addr !== 8'h50 || mem_write_data !== 8'h01) begin errors++; $display("FAIL b2b_stall_drain got en=%b a=%h d=%h exp 1/50/01", mem_en, mem_write_addr, mem_write_data); end
    tick;
    #1;
    checks++; if (req_ready !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL b2b_retry got ready=%b en=%b exp 1/0", req_ready, mem_en); end
    tick;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", sb_count); end
    for (int i = 0; i < 5; i++) tick;
    checks++; if (wlog_a.size() - base !== 5) begin errors++; $display("FAIL b2b_nwrites got %0d exp 5", wlog_a.size() - base); end
    for (int i = 0; i < 5; i++) begin
      ea = 8'h50 + 8'(i);
      ed = 8'(i + 1);
      if (base + i < wlog_a.size()) begin
        checks++; if (wlog_a[base + i] !== ea || wlog_d[base + i] !== ed) begin errors++; $display("FAIL b2b_order%0d got %h/%h exp %h/%h", i, wlog_a[base + i], wlog_d[base + i], ea, ed); end
      end
    end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", sb_empty); end
  endtask

  task automatic test_load_priority;
    logic [7:0] la [4];
    logic [7:0] ld [4];
    la[0] = 8'h60; ld[0] = 8'hA1;
    la[1] = 8'h70; ld[1] = 8'h77;
    la[2] = 8'h61; ld[2] = 8'hA2;
    la[3] = 8'h70; ld[3] = 8'h77;
    drive(1'b1, 1'b1, 8'h60, 8'hA1);
    tick;
    drive(1'b1, 1'b1, 8'h61, 8'hA2);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, la[i], 8'h00);
      #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL prio_no_drain%0d got %b exp 0", i, mem_en); end
      tick;
      checks++; if (resp_valid !== 1'b1 || resp_data !== ld[i]) begin errors++; $display("FAIL prio_resp%0d got v=%b d=%h exp 1/%h", i, resp_valid, resp_data, ld[i]); end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    checks++; if (sb_count !== 3'd2) begin errors++; $display("FAIL prio_count got %0d exp 2", sb_count); end
    tick;
    tick;
    checks++; if (mem[8'h60] !== 8'hA1 || mem[8'h61] !== 8'hA2 || sb_empty !== 1'b1) begin errors++; $display("FAIL prio_drained got %h/%h empty=%b exp a1/a2/1", mem[8'h60], mem[8'h61], sb_empty); end
  endtask

  task automatic test_reset_mid_drain;
    int base;
    int pulses;
    base = wr_total;
    pulses = 0;
    drive(1'b1, 1'b1, 8'h90, 8'hB0);
    tick;
    drive(1'b1, 1'b1, 8'h91, 8'hB1);
    tick;
    drive(1'b1, 1'b1, 8'h92, 8'hB2);
    tick;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick;
    checks++; if (mem_en !== 1'b1 || mem_write_addr !== 8'h91) begin errors++; $display("FAIL rstmid_pre got en=%b a=%h exp 1/91", mem_en, mem_write_addr); end
    #1 rst = 1'b1;
    #1;
    checks++; if (sb_count !== 3'd0 || sb_empty !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_async got count=%0d empty=%b en=%b exp 0/1/0", sb_count, sb_empty, mem_en); end
    checks++; if (resp_valid !== 1'b0 || resp_data !== 8'h00) begin errors++; $display("FAIL rstmid_resp got v=%b d=%h exp 0/00", resp_valid, resp_data); end
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_en) pulses++;
      tick;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_pulses got %0d exp 0", pulses); end
    checks++; if (wr_total - base !== 1) begin errors++; $display("FAIL rstmid_writes got %0d exp 1", wr_total - base); end
    checks++; if (mem[8'h90] !== 8'hB0 || mem[8'h91] !== 8'h00 || mem[8'h92] !== 8'h00) begin errors++; $display("FAIL rstmid_mem got %h/%h/%h exp b0/00/00", mem[8'h90], mem[8'h91], mem[8'h92]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h10] <= 8'h5A;
    mem[8'h70] <= 8'h77;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    test_reset;
    test_load;
    test_forward;
    test_merge;
    test_back_to_back;
    test_load_priority;
    test_reset_mid_drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
